// File: rtl/hazard_stall_unit_if.sv
// ID-stage hazard/clear-control bundle between the pipeline and the hazard stall unit.
// With HAZARD_STATS_EN defined, the bundle also carries stall_cycles and flush_count.
interface hazard_stall_unit_if #(
    parameter int unsigned REG_W = 5
);
    logic [31:0]      id_instru;
    logic             idex_MemRead;
    logic             idex_RegWrite;
    logic [REG_W-1:0] idex_dst;
    logic             exmem_MemRead;
    logic [REG_W-1:0] exmem_dst;
    logic             id_branch_taken;
    logic             c_clearControl;
    logic             pc_write;
    logic             ifid_write;
    logic             if_flush;
    logic             stalling;
`ifdef HAZARD_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      flush_count;

    // Hazard unit side: consumes pipeline status, drives stall/flush controls and counters
    modport master (
        input  id_instru, idex_MemRead, idex_RegWrite, idex_dst,
               exmem_MemRead, exmem_dst, id_branch_taken,
        output c_clearControl, pc_write, ifid_write, if_flush, stalling,
               stall_cycles, flush_count
    );

    // Pipeline side: supplies status, obeys controls
    modport slave (
        output id_instru, idex_MemRead, idex_RegWrite, idex_dst,
               exmem_MemRead, exmem_dst, id_branch_taken,
        input  c_clearControl, pc_write, ifid_write, if_flush, stalling,
               stall_cycles, flush_count
    );
`else
    // Hazard unit side: consumes pipeline status, drives stall/flush controls
    modport master (
        input  id_instru, idex_MemRead, idex_RegWrite, idex_dst,
               exmem_MemRead, exmem_dst, id_branch_taken,
        output c_clearControl, pc_write, ifid_write, if_flush, stalling
    );

    // Pipeline side: supplies status, obeys controls
    modport slave (
        output id_instru, idex_MemRead, idex_RegWrite, idex_dst,
               exmem_MemRead, exmem_dst, id_branch_taken,
        input  c_clearControl, pc_write, ifid_write, if_flush, stalling
    );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / branch-operand hazard detection and stall sequencing for the ID stage.
// Branches resolve in ID, so their operands must be final before they leave ID.
// Optional macro HAZARD_STATS_EN adds stall_cycles / flush_count counters.
module hazard_stall_unit #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned LW_BR_STALL  = 2,
    parameter int unsigned ALU_BR_STALL = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_stall_unit_if.master  hz
);
    localparam int unsigned CNT_W = 2;
    localparam int unsigned LEN_W = 3;
    localparam logic [LEN_W-1:0] LW_BR_N  = LEN_W'(LW_BR_STALL);
    localparam logic [LEN_W-1:0] ALU_BR_N = LEN_W'(ALU_BR_STALL);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic {RUN, STALL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [5:0]       opcode;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] idex_dst;
    logic [REG_W-1:0] exmem_dst;
    logic             reads_rs;
    logic             reads_rt;
    logic             is_branch;
    logic             is_jump;
    logic             ex_match;
    logic             mem_match;
    logic             haz_bl;
    logic             haz_ba;
    logic             haz_bm;
    logic             haz_lu;
    logic [LEN_W-1:0] hz_len;

    logic             c_clear;
    logic             pc_we;
    logic             ifid_we;
    logic             flush;
    logic             unused_ok;

    assign opcode    = hz.id_instru[31:26];
    assign rs        = REG_W'(hz.id_instru[25:21]);
    assign rt        = REG_W'(hz.id_instru[20:16]);
    assign idex_dst  = hz.idex_dst;
    assign exmem_dst = hz.exmem_dst;
    assign unused_ok = ^hz.id_instru[15:0];

    // Decode which source registers the ID instruction actually reads
    always_comb begin
        reads_rs  = 1'b0;
        reads_rt  = 1'b0;
        is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump   = (opcode == OP_J);
        case (opcode)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            OP_ADDI, OP_ANDI, OP_LW: reads_rs = 1'b1;
            default: ;
        endcase
    end

    // Register 0 is hardwired, so a write to it is never a dependency
    assign ex_match  = (idex_dst != '0) &&
                       ((reads_rs && (rs == idex_dst)) || (reads_rt && (rt == idex_dst)));
    assign mem_match = (exmem_dst != '0) &&
                       ((reads_rs && (rs == exmem_dst)) || (reads_rt && (rt == exmem_dst)));

    assign haz_bl = is_branch && hz.idex_MemRead && ex_match;
    assign haz_ba = is_branch && hz.idex_RegWrite && !hz.idex_MemRead && ex_match;
    assign haz_bm = is_branch && hz.exmem_MemRead && mem_match;
    assign haz_lu = !is_branch && hz.idex_MemRead && ex_match;

    // Highest-priority hazard class picks the stall length; zero means no hazard
    always_comb begin
        hz_len = '0;
        if (haz_bl) begin
            hz_len = LW_BR_N;
        end else if (haz_ba || haz_bm) begin
            hz_len = ALU_BR_N;
        end else if (haz_lu) begin
            hz_len = LEN_W'(1);
        end
    end

    // State and remaining-stall counter; single-cycle stalls stay in RUN and re-evaluate
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz_len > LEN_W'(1)) begin
                        state <= STALL;
                        cnt   <= CNT_W'(hz_len - LEN_W'(1));
                    end
                end
                STALL: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Stall/flush controls; a stalled branch or jump flushes only once released
    always_comb begin
        c_clear = 1'b0;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        if (rst) begin
            c_clear = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            flush   = 1'b1;
        end else if ((state == STALL) || (hz_len != '0)) begin
            c_clear = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else begin
            flush = hz.id_branch_taken || is_jump;
        end
    end

    assign hz.c_clearControl = c_clear;
    assign hz.pc_write       = pc_we;
    assign hz.ifid_write     = ifid_we;
    assign hz.if_flush       = flush;
    assign hz.stalling       = (state == STALL) && !rst;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Free-running stall and flush event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_we) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (flush) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with a per-cycle reference model.
module tb_hazard_stall_unit;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] ADD_9_8  = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] ADD_9_0  = {6'h00, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
    localparam logic [31:0] BEQ_4_5  = {6'h04, 5'd4, 5'd5, 16'h0010};
    localparam logic [31:0] BNE_3_0  = {6'h05, 5'd3, 5'd0, 16'h0020};
    localparam logic [31:0] J_RS8    = {6'h02, 5'd8, 21'h000040};
    localparam int          LW_BR_LEN  = 2;
    localparam int          ALU_BR_LEN = 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   rem;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    hazard_stall_unit_if #(.REG_W(5)) bus ();

    hazard_stall_unit #(
        .REG_W(5),
        .LW_BR_STALL(2),
        .ALU_BR_STALL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stall length demanded by the rules: 0 = none
    function automatic int hazard_len(input logic [31:0] ins, input logic ex_mr,
                                      input logic ex_rw, input logic [4:0] ex_d,
                                      input logic mem_mr, input logic [4:0] mem_d);
        logic [5:0]  op;
        logic [31:0] reads;
        bit          br;
        int          len;
        op    = ins[31:26];
        reads = '0;
        len   = 0;
        if (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05) begin
            reads[ins[25:21]] = 1'b1;
            reads[ins[20:16]] = 1'b1;
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h23) begin
            reads[ins[25:21]] = 1'b1;
        end
        reads[0] = 1'b0;
        br = (op == 6'h04) || (op == 6'h05);
        if (br) begin
            if (ex_mr && reads[ex_d]) len = LW_BR_LEN;
            else if ((ex_rw && !ex_mr && reads[ex_d]) || (mem_mr && reads[mem_d])) len = ALU_BR_LEN;
        end else if (ex_mr && reads[ex_d]) begin
            len = 1;
        end
        return len;
    endfunction

    // Reference model: rem counts forced stall cycles still owed
    always @(negedge clk) begin
        logic e_cc, e_pw, e_iw, e_fl, e_st;
        int   n, next_rem;
        e_cc = 1'b0; e_pw = 1'b1; e_iw = 1'b1; e_fl = 1'b0; e_st = 1'b0;
        next_rem = 0;
        if (rst) begin
            e_cc = 1'b1; e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b1;
        end else if (rem > 0) begin
            e_cc = 1'b1; e_pw = 1'b0; e_iw = 1'b0; e_st = 1'b1;
            next_rem = rem - 1;
        end else begin
            n = hazard_len(bus.id_instru, bus.idex_MemRead, bus.idex_RegWrite, bus.idex_dst,
                           bus.exmem_MemRead, bus.exmem_dst);
            if (n > 0) begin
                e_cc = 1'b1; e_pw = 1'b0; e_iw = 1'b0;
                next_rem = n - 1;
            end else begin
                e_fl = bus.id_branch_taken || (bus.id_instru[31:26] == 6'h02);
            end
        end
        check("model_c_clearControl", 32'(bus.c_clearControl), 32'(e_cc));
        check("model_pc_write", 32'(bus.pc_write), 32'(e_pw));
        check("model_ifid_write", 32'(bus.ifid_write), 32'(e_iw));
        check("model_if_flush", 32'(bus.if_flush), 32'(e_fl));
        check("model_stalling", 32'(bus.stalling), 32'(e_st));
`ifdef HAZARD_STATS_EN
        if (!$isunknown(m_stall)) begin
            check("model_stall_cycles", bus.stall_cycles, m_stall);
            check("model_flush_count", bus.flush_count, m_flush);
        end
        if (rst) begin
            m_stall <= 32'd0;
            m_flush <= 32'd0;
        end else begin
            m_stall <= m_stall + (e_pw ? 32'd0 : 32'd1);
            m_flush <= m_flush + (e_fl ? 32'd1 : 32'd0);
        end
`endif
        rem <= next_rem;
    end

    // One pipeline cycle: drive after the edge, settle before sampling
    task automatic step(input logic r, input logic [31:0] ins, input logic emr, input logic erw,
                        input logic [4:0] ed, input logic mmr, input logic [4:0] md,
                        input logic tk);
        @(posedge clk);
        #1;
        rst                 = r;
        bus.id_instru       = ins;
        bus.idex_MemRead    = emr;
        bus.idex_RegWrite   = erw;
        bus.idex_dst        = ed;
        bus.exmem_MemRead   = mmr;
        bus.exmem_dst       = md;
        bus.id_branch_taken = tk;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_ctl(input string tag, input logic cc, input logic pw,
                              input logic fl, input logic st);
        check({tag, "_cc"}, 32'(bus.c_clearControl), 32'(cc));
        check({tag, "_pw"}, 32'(bus.pc_write), 32'(pw));
        check({tag, "_iw"}, 32'(bus.ifid_write), 32'(pw));
        check({tag, "_fl"}, 32'(bus.if_flush), 32'(fl));
        check({tag, "_st"}, 32'(bus.stalling), 32'(st));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rem    = 0;
        m_stall = 'x;
        m_flush = 'x;
        rst = 1'b1;
        bus.id_instru = NOP; bus.idex_MemRead = 1'b0; bus.idex_RegWrite = 1'b0;
        bus.idex_dst = 5'd0; bus.exmem_MemRead = 1'b0; bus.exmem_dst = 5'd0;
        bus.id_branch_taken = 1'b0;

        step(1'b1, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1'b1, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("reset", 1'b1, 1'b0, 1'b1, 1'b0);

        // Load-use: one bubble, then clear once EX holds the bubble
        step(1'b0, ADD_9_8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        expect_ctl("lu_stall", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, ADD_9_8, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        expect_ctl("lu_release", 1'b0, 1'b1, 1'b0, 1'b0);

        // Branch after lw in EX: two stall cycles, the second in STALL
        step(1'b0, BEQ_4_5, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        expect_ctl("bl_first", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, BEQ_4_5, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b1);
        expect_ctl("bl_second", 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, BEQ_4_5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        expect_ctl("bl_taken", 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_STATS_EN
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("stats_stall_cycles", bus.stall_cycles, 32'd3);
        check("stats_flush_count", bus.flush_count, 32'd1);
`endif
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("nop_after_br", 1'b0, 1'b1, 1'b0, 1'b0);

        // Branch after ALU op in EX: single stall, never enters STALL
        step(1'b0, BNE_3_0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1);
        expect_ctl("ba_stall", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, BNE_3_0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0);
        expect_ctl("ba_release", 1'b0, 1'b1, 1'b0, 1'b0);

        // Jump: flush, no data hazard even when its target bits look like rs=8
        step(1'b0, J_RS8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        expect_ctl("jump", 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, ADD_9_0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        expect_ctl("reg0", 1'b0, 1'b1, 1'b0, 1'b0);

        // Branch after lw in MEM: residual hazard restarts the stall
        step(1'b0, BEQ_4_5, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        expect_ctl("bm_first", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, BEQ_4_5, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1);
        expect_ctl("bm_residual", 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, BEQ_4_5, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("bm_release", 1'b0, 1'b1, 1'b0, 1'b0);

        // BL outranks BM when both hold
        step(1'b0, BEQ_4_5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd4, 1'b0);
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("prio_stall", 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("prio_done", 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset in the STALL cycle aborts the stall
        step(1'b0, BEQ_4_5, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        step(1'b1, BEQ_4_5, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0);
        expect_ctl("rst_mid", 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("rst_after", 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
        check("stats_rst_stall", bus.stall_cycles, 32'd0);
        check("stats_rst_flush", bus.flush_count, 32'd0);
`endif
        step(1'b0, NOP, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ctl("idle", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
